// File: rtl/dot_sequencer.sv
// dot_sequencer: buffers N (x, w) operand pairs and streams them, one pair per
// cycle, to a downstream MAC. It then waits for the MAC's done pulse, captures
// the accumulated result, and holds it until the consumer accepts it.
// Optional feature macro: DOT_SEQUENCER_RELU_EN (clamps a negative result to 0).
module dot_sequencer #(
  parameter int N  = 4,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          go,
  output logic          busy,
  output logic          mac_start,
  output logic [15:0]   mac_x,
  output logic [15:0]   mac_w,
  input  logic [15:0]   mac_acc,
  input  logic          mac_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, HOLD} state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;
  logic          mac_start_q;
  logic [15:0]   mac_x_q;
  logic [15:0]   mac_w_q;
  logic          res_valid_q;
  logic [15:0]   res_data_q;
  logic [15:0]   x_q [N];
  logic [15:0]   w_q [N];

  logic          wr_ok;
  logic [AW-1:0] idx_nxt;
  logic          last_elem;
  logic [15:0]   x0_d;
  logic [15:0]   w0_d;
  logic [15:0]   cap_d;

  // Writes land only while idle and only for an in-range element index.
  assign wr_ok     = (state_q == IDLE) && wr_en && (32'(wr_addr) < N);
  assign idx_nxt   = idx_q + 1'b1;
  assign last_elem = (32'(idx_q) == N - 1);

  // Element 0 is read on the same edge that accepts go, so a write to it on
  // that edge must be forwarded rather than read from the stale buffer.
  assign x0_d = (wr_ok && !wr_sel && (wr_addr == '0)) ? wr_data : x_q[0];
  assign w0_d = (wr_ok &&  wr_sel && (wr_addr == '0)) ? wr_data : w_q[0];

`ifdef DOT_SEQUENCER_RELU_EN
  assign cap_d = mac_acc[15] ? 16'h0000 : mac_acc;
`else
  assign cap_d = mac_acc;
`endif

  // Operand buffers: cleared by reset, written only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < N; i++) begin
        if (32'(wr_addr) == i) begin
          if (wr_sel) w_q[i] <= wr_data;
          else        x_q[i] <= wr_data;
        end
      end
    end
  end

  // Sequencer FSM with all outputs registered; MAC operand outputs default to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      mac_start_q <= 1'b0;
      mac_x_q     <= '0;
      mac_w_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mac_start_q <= 1'b0;
      mac_x_q     <= '0;
      mac_w_q     <= '0;
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q     <= STREAM;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            mac_start_q <= 1'b1;
            mac_x_q     <= x0_d;
            mac_w_q     <= w0_d;
          end
        end
        STREAM: begin
          if (last_elem) begin
            state_q <= WAIT;
          end else begin
            idx_q   <= idx_nxt;
            mac_x_q <= x_q[idx_nxt];
            mac_w_q <= w_q[idx_nxt];
          end
        end
        WAIT: begin
          if (mac_done) begin
            state_q     <= HOLD;
            res_valid_q <= 1'b1;
            res_data_q  <= cap_d;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign mac_start = mac_start_q;
  assign mac_x     = mac_x_q;
  assign mac_w     = mac_w_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
